// File: rtl/seq_mul_nbit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_mul_nbit                                                 |
// | Description : Radix-2 shift-add multiplier, signed/unsigned, full product, |
// |               valid/ready handshakes. SEQ_MUL_EARLY_TERM_EN enables early  |
// |               termination once the remaining multiplier bits are zero.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_mul_nbit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] P_lo,
  output logic [WIDTH-1:0] P_hi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_q, neg_d;

  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic [2*WIDTH-1:0]     w_acc_sum;
  logic [WIDTH-1:0]       w_mplier_shift;
  logic                   w_last;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
  assign w_abs_a = (is_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign w_abs_b = (is_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  assign w_acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign w_mplier_shift = mplier_q >> 1;

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign w_last = (cnt_q == c_last_cnt) || (w_mplier_shift == '0);
`else
  assign w_last = (cnt_q == c_last_cnt);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, w_abs_a};
          mplier_d = w_abs_b;
          cnt_d    = '0;
          neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = w_acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = w_mplier_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (w_last) begin
          prod_d  = neg_q ? (~w_acc_sum + (2*WIDTH)'(1)) : w_acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign P_lo      = prod_q[WIDTH-1:0];
  assign P_hi      = prod_q[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire
